// File: rtl/me_control.sv
// Sequencing controller for the full-search motion estimator: address streaming, PE enables,
// peready strobes and comparator control. Optional early stop on a zero distortion: ME_ZERO_STOP_EN.
module me_control #(
  parameter int unsigned PASSES = 16,
  parameter int unsigned DIST_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        compstart,
  output logic [15:0] pe_en,
  output logic [15:0] peready,
  output logic [3:0]  vectorX,
  output logic [3:0]  vectorY,
  output logic [7:0]  addressR,
  output logic [9:0]  addressS
`ifdef ME_ZERO_STOP_EN
  ,
  input  logic [DIST_W-1:0] bestdist
`endif
);

  if (PASSES < 1 || PASSES > 16 || DIST_W < 1) begin : g_cfg_check
    $error("me_control: PASSES must be 1..16 and DIST_W at least 1");
  end

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  localparam logic [8:0] LcLast = 9'd271;
  localparam logic [3:0] VyLast = 4'(PASSES - 1);

  state_e      state_q;
  logic [8:0]  lc_q;
  logic [3:0]  vy_q;
  logic        zero_hit;
  logic        run_end;

`ifdef ME_ZERO_STOP_EN
  // A zero distortion cannot be improved on, so the remaining passes are skipped.
  assign zero_hit = (bestdist == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign run_end = (vy_q == VyLast) || zero_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lc_q    <= '0;
      vy_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) state_q <= StInit;
        end
        StInit: begin
          state_q <= StRun;
          lc_q    <= '0;
          vy_q    <= '0;
        end
        StRun: begin
          if (lc_q == LcLast) begin
            lc_q <= '0;
            if (run_end) begin
              state_q <= StDone;
              vy_q    <= '0;
            end else begin
              vy_q <= vy_q + 4'd1;
            end
          end else begin
            lc_q <= lc_q + 9'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic       run;
  logic       stream;
  logic [4:0] row_sum;

  always_comb begin
    run       = (state_q == StRun);
    stream    = run && !lc_q[8];
    busy      = (state_q == StInit) || run;
    done      = (state_q == StDone);
    compstart = run || done;
    row_sum   = {1'b0, vy_q} + {1'b0, lc_q[7:4]};

    pe_en   = '0;
    peready = '0;
    for (int i = 0; i < 16; i++) begin
      pe_en[i]   = run && (lc_q >= 9'(i)) && (lc_q <= 9'(i + 255));
      peready[i] = run && (lc_q == 9'(i + 256));
    end

    // In the tail (lc 256..271) lc - 256 is simply the low nibble.
    vectorX  = (run && lc_q[8]) ? lc_q[3:0] : 4'd0;
    vectorY  = run ? vy_q : 4'd0;
    addressR = stream ? lc_q[7:0] : 8'd0;
    addressS = stream ? {row_sum, 1'b0, lc_q[3:0]} : 10'd0;
  end

endmodule

// File: tb/tb_me_control.sv
// Scoreboard bench for me_control: a cycle-count reference model feeds expected outputs to a
// queue that a negedge monitor drains and compares against the DUT.
module tb_me_control;

  localparam int unsigned PASSES  = 16;
  localparam int unsigned DIST_W  = 8;
  localparam int          PassLen = 272;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, compstart;
  logic [15:0] pe_en, peready;
  logic [3:0]  vectorX, vectorY;
  logic [7:0]  addressR;
  logic [9:0]  addressS;
`ifdef ME_ZERO_STOP_EN
  logic [DIST_W-1:0] bestdist = '1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  me_control #(
    .PASSES(PASSES),
    .DIST_W(DIST_W)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .compstart(compstart),
    .pe_en    (pe_en),
    .peready  (peready),
    .vectorX  (vectorX),
    .vectorY  (vectorY),
    .addressR (addressR),
    .addressS (addressS)
`ifdef ME_ZERO_STOP_EN
    ,
    .bestdist (bestdist)
`endif
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cs;
    logic [15:0] pe_en;
    logic [15:0] peready;
    logic [3:0]  vx;
    logic [3:0]  vy;
    logic [7:0]  ar;
    logic [9:0]  as;
  } obs_t;

  obs_t exp_q[$];

  // Reference model: a run is "cycles since start accepted" (t); t=0 is INIT, t=1..len is the
  // sweep, beyond that the run is finished.
  bit m_act = 1'b0;
  int m_t   = 0;
  int m_len = PASSES * PassLen;

  function automatic obs_t model_out(input bit act, input int t, input int len);
    obs_t o;
    int   k, p, c;
    o = '0;
    if (!act) return o;
    if (t == 0) begin
      o.busy = 1'b1;
    end else if (t <= len) begin
      k = t - 1;
      p = k / PassLen;
      c = k % PassLen;
      o.busy = 1'b1;
      o.cs   = 1'b1;
      o.vy   = 4'(p);
      if (c < 256) begin
        o.ar = 8'(c);
        o.as = 10'((p + c / 16) * 32 + c % 16);
      end else begin
        o.vx      = 4'(c - 256);
        o.peready = 16'd1 << (c - 256);
      end
      for (int i = 0; i < 16; i++) o.pe_en[i] = (c >= i) && (c <= i + 255);
    end else begin
      o.done = 1'b1;
      o.cs   = 1'b1;
    end
    return o;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0;
      m_t   = 0;
      m_len = PASSES * PassLen;
    end else if (m_act && m_t <= m_len) begin
`ifdef ME_ZERO_STOP_EN
      if (m_t >= 1 && (m_t - 1) % PassLen == PassLen - 1 && bestdist == '0)
        m_len = ((m_t - 1) / PassLen + 1) * PassLen;
`endif
      m_t = m_t + 1;
    end else if (start) begin
      m_act = 1'b1;
      m_t   = 0;
      m_len = PASSES * PassLen;
    end
  end

  always @(posedge clk) begin
    #1;
    exp_q.push_back(model_out(m_act, m_t, m_len));
  end

  obs_t got_o, exp_o;
  always @(negedge clk) begin
    got_o = {busy, done, compstart, pe_en, peready, vectorX, vectorY, addressR, addressS};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty t=%0t got %h", $time, got_o);
    end else begin
      exp_o = exp_q.pop_front();
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL outputs t=%0t got busy=%b done=%b cs=%b pe_en=%h peready=%h vx=%0d vy=%0d ar=%h as=%0d | want busy=%b done=%b cs=%b pe_en=%h peready=%h vx=%0d vy=%0d ar=%h as=%0d",
                 $time, got_o.busy, got_o.done, got_o.cs, got_o.pe_en, got_o.peready, got_o.vx,
                 got_o.vy, got_o.ar, got_o.as, exp_o.busy, exp_o.done, exp_o.cs, exp_o.pe_en,
                 exp_o.peready, exp_o.vx, exp_o.vy, exp_o.ar, exp_o.as);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    #1 start = 1'b1;
`ifdef ME_ZERO_STOP_EN
    bestdist = '1;
`endif
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  // Random ignored start pulses while running; bounded wait for done.
  task automatic run_to_done();
    bit seen = 1'b0;
    for (int c = 0; c < PASSES * PassLen + 20; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      #1 start = ($urandom_range(0, 63) == 0);
`ifdef ME_ZERO_STOP_EN
      bestdist = ($urandom_range(0, 399) == 0) ? '0 : DIST_W'($urandom_range(1, 255));
`endif
    end
    #1 start = 1'b0;
`ifdef ME_ZERO_STOP_EN
    bestdist = '1;
`endif
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout got done=%b want 1", done);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);

    // Full run with spurious starts, then idle in DONE.
    pulse_start();
    run_to_done();
    repeat ($urandom_range(3, 10)) @(negedge clk);

    // Restart from DONE, reset (with simultaneous start) at pass 5, lc 100.
    pulse_start();
    repeat (5 * PassLen + 101) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    start = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, compstart, pe_en, peready, vectorX, vectorY, addressR, addressS} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got busy=%b done=%b cs=%b pe_en=%h peready=%h want all zero",
               busy, done, compstart, pe_en, peready);
    end
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);

    // Start held across INIT: the second sample must be ignored.
    @(negedge clk);
    #1 start = 1'b1;
    repeat (2) @(negedge clk);
    #1 start = 1'b0;
    run_to_done();

    // Start again from DONE and finish.
    repeat ($urandom_range(1, 5)) @(negedge clk);
    pulse_start();
    run_to_done();
    repeat (3) @(negedge clk);

    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/me_control.md
Name: me_control

Overview:
Sequencing controller for the full-search motion estimator. It drives the 16-PE distortion array and the best-match comparator. For each candidate vectorY (one "pass"), it streams the 16x16 reference block and search-window addresses, staggers the 16 PE enables, and issues one-hot `peready` strobes tagged with vectorX/vectorY. It also controls `compstart` so the comparator resets and then accumulates the best distortion across one run.

Parameters:
PASSES, 16, number of vectorY passes per run (1..16); vectorY sweeps 0..PASSES-1.
DIST_W, 8, width of the bestdist input (used only with ME_ZERO_STOP_EN).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a new run; sampled in IDLE or DONE only
busy  out  1  high in INIT and RUN
done  out  1  high while in DONE (level, held until next start or reset)
compstart  out  1  comparator enable; 0 makes the comparator reinitialise bestdist to 8'hFF
pe_en  out  16  per-PE accumulate enable
peready  out  16  one-hot strobe: PE i distortion is valid on peout this cycle
vectorX  out  4  candidate X for the asserted peready bit
vectorY  out  4  current pass index
addressR  out  8  reference-block pixel address {row[3:0],col[3:0]}
addressS  out  10  search-window base address, stride 32
bestdist  in  DIST_W  comparator best distortion (port exists only with ME_ZERO_STOP_EN)

Behaviour:
- State: FSM IDLE/INIT/RUN/DONE; 9-bit local counter lc (0..271); 4-bit pass counter vy.
- Outputs: all outputs decode combinationally from registered state/lc/vy only. There is no combinational path from input to output.
- Reset (async, any time, including mid-run): state=IDLE, lc=0, vy=0. All outputs are 0; compstart=0.
- IDLE: start=1 -> INIT.
- DONE: start=1 -> INIT; otherwise hold.
- INIT (exactly 1 cycle): compstart=0 so the comparator clears to 8'hFF; lc=0, vy=0; next state RUN.
- RUN:
  - compstart=1; lc increments every cycle.
  - At lc=271: lc wraps to 0 and vy increments.
  - At lc=271 with vy=PASSES-1: next state DONE.
  - Pass length is 272 cycles; RUN length is PASSES*272 cycles (4352 at default).
- Address stream, lc<256:
  - addressR = lc[7:0].
  - addressS = ((vy + lc[7:4]) << 5) | lc[3:0]; maximum value is 975.
  - The PE array applies the per-PE column offset i and the stagger delay internally.
- Address stream, lc>=256: addressR and addressS hold 0.
- pe_en[i] = RUN && (i <= lc <= i+255).
- peready[i] = RUN && (lc == 256+i). Exactly one bit is set for lc in 256..271; all bits are 0 otherwise.
- vectorX = lc-256 when lc>=256, else 0.
- vectorY = vy in RUN, else 0.
- DONE: compstart stays 1 so the comparator holds motionX/motionY/bestdist. pe_en, peready and the addresses are 0. busy=0, done=1.
- start in INIT or RUN: ignored; no restart and no effect on counters.
- start and reset simultaneously: reset wins.

Optional Feature:
ME_ZERO_STOP_EN
- Defined: adds the bestdist input. In RUN at lc=271, if bestdist==0, the next state is DONE regardless of vy, because a perfect match cannot be beaten. The check uses the bestdist value sampled on that cycle, so it covers PEs 0..14 of the current pass. A PE-15 zero is caught at the next pass end or at the run end.
- Undefined: no bestdist port; the run always completes PASSES passes.

Test Plan:
1. Reset -> pulse start -> 1 cycle with busy=1, compstart=0, pe_en=0. Next cycle: RUN, compstart=1, pe_en=16'h0001, addressR=0, addressS=0.
2. Pass 0, lc=16 -> pe_en=16'hFFFF. At lc=17: addressR=8'h11, addressS=33. At lc=256: pe_en=16'hFFFE.
3. Pass 0, lc=256 -> peready=16'h0001, vectorX=0, vectorY=0. At lc=271: peready=16'h8000, vectorX=15. Next cycle: vectorY=1, pe_en=16'h0001.
4. Pass 3, lc=37 -> addressR=37, addressS=((3+2)<<5)|5=165. Assert start here -> no effect; done arrives on schedule.
5. Full default run -> done=1 exactly 4352 cycles after RUN entry; compstart stays 1 in DONE. Start in DONE -> compstart=0 for 1 cycle, then a new run begins. Reset asserted at pass 5, lc=100 -> all outputs 0 immediately; IDLE after reset release.
6. ME_ZERO_STOP_EN defined, bestdist=0 at lc=271 of pass 2 -> DONE next cycle; vectorY never reaches 3. With the macro undefined, the same stimulus runs all 16 passes.
